mirfak_clint: RTL

MIRFAK_CLINT -- requirements
Module: mirfak_clint

---
 rtl/mirfak_clint_if.sv | 35 +++
 rtl/mirfak_clint.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mirfak_clint_if.sv
// mirfak_clint_if -- Wishbone classic slave bus bundle for the CLINT.
//
// Signals (names kept from the flat-port original):
//   wbs_addr_i [15:0]  byte address, bits [1:0] ignored by the slave
//   wbs_dat_i  [31:0]  write data
//   wbs_sel_i  [3:0]   byte enables
//   wbs_we_i           1 = write
//   wbs_cyc_i          bus cycle valid
//   wbs_stb_i          strobe
//   wbs_dat_o  [31:0]  read data, valid only while wbs_ack_o = 1
//   wbs_ack_o          access completed
//   wbs_err_o          access to an unmapped address
//
// Modports: slave (the CLINT), master (the bus host / testbench).
interface mirfak_clint_if;
    logic [15:0] wbs_addr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;

    modport slave (
        input  wbs_addr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o
    );

    modport master (
        output wbs_addr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o
    );
endinterface

// File: rtl/mirfak_clint.sv
// mirfak_clint -- RISC-V core-local interruptor (msip, mtime, mtimecmp).
//
// Parameters:
//   PRESCALER    mtime advances once every PRESCALER clk_i cycles (1..65535)
//   MTIME_RESET  value loaded into mtime on reset
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_ni       synchronous active-low reset
//   wbs          Wishbone slave bus (mirfak_clint_if.slave)
//   xint_mtip_o  machine timer interrupt pending (registered mtime >= mtimecmp)
//   xint_msip_o  machine software interrupt pending (msip bit 0)
//
// Register map (word address = wbs_addr_i[15:2]):
//   0x0000 msip (bit 0)   0x4000/0x4004 mtimecmp lo/hi   0xBFF8/0xBFFC mtime lo/hi
// Each request is answered one cycle later by a one-cycle ack (mapped) or
// err (unmapped) pulse.
module mirfak_clint #(
    parameter int unsigned PRESCALER   = 1,
    parameter logic [63:0] MTIME_RESET = 64'h0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mirfak_clint_if.slave wbs,
    output logic          xint_mtip_o,
    output logic          xint_msip_o
);

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACK,
        BUS_ERR
    } bus_state_e;

    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI,
        REG_NONE
    } reg_sel_e;

    localparam logic [15:0] PRE_LAST = 16'(PRESCALER - 1);

    bus_state_e  state_q, state_d;
    reg_sel_e    reg_sel;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic        tick;
    logic        mtip_q;
    logic [31:0] dat_q, rdata;

    logic        req, wr_en, rd_en;
    logic        unused_addr_bits;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] result;
        result = old_w;
        for (int unsigned b = 0; b < 4; b++) begin
            if (sel[b]) result[8*b +: 8] = new_w[8*b +: 8];
        end
        return result;
    endfunction

    assign unused_addr_bits = ^wbs.wbs_addr_i[1:0];

    // Address decode on the word address only.
    always_comb begin
        reg_sel = REG_NONE;
        case (wbs.wbs_addr_i[15:2])
            14'h0000: reg_sel = REG_MSIP;
            14'h1000: reg_sel = REG_CMP_LO;
            14'h1001: reg_sel = REG_CMP_HI;
            14'h2FFE: reg_sel = REG_TIME_LO;
            14'h2FFF: reg_sel = REG_TIME_HI;
            default:  reg_sel = REG_NONE;
        endcase
    end

    // A response cycle blocks new requests, which keeps ack/err single-cycle.
    assign req   = wbs.wbs_cyc_i & wbs.wbs_stb_i & (state_q == BUS_IDLE);
    assign wr_en = req & wbs.wbs_we_i & (reg_sel != REG_NONE);
    assign rd_en = req & ~wbs.wbs_we_i & (reg_sel != REG_NONE);

    always_comb begin
        state_d = BUS_IDLE;
        if (req) begin
            state_d = (reg_sel == REG_NONE) ? BUS_ERR : BUS_ACK;
        end
    end

    // Prescaler: mtime ticks when the counter sits at its last value.
    assign tick      = (pre_cnt_q == PRE_LAST);
    assign pre_cnt_d = tick ? '0 : pre_cnt_q + 16'd1;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_MSIP:    rdata = {31'b0, msip_q};
            REG_CMP_LO:  rdata = mtimecmp_q[31:0];
            REG_CMP_HI:  rdata = mtimecmp_q[63:32];
            REG_TIME_LO: rdata = mtime_q[31:0];
            REG_TIME_HI: rdata = mtime_q[63:32];
            default:     rdata = '0;
        endcase
    end

    // Bus writes to mtime merge into the already-incremented value, so bytes
    // not written still see the tick of this cycle.
    always_comb begin
        mtime_d    = mtime_q + 64'(tick);
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_en) begin
            case (reg_sel)
                REG_MSIP:    if (wbs.wbs_sel_i[0]) msip_d = wbs.wbs_dat_i[0];
                REG_CMP_LO:  mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0],  wbs.wbs_dat_i, wbs.wbs_sel_i);
                REG_CMP_HI:  mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i);
                REG_TIME_LO: mtime_d[31:0]     = byte_merge(mtime_d[31:0],     wbs.wbs_dat_i, wbs.wbs_sel_i);
                REG_TIME_HI: mtime_d[63:32]    = byte_merge(mtime_d[63:32],    wbs.wbs_dat_i, wbs.wbs_sel_i);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= BUS_IDLE;
            mtime_q    <= MTIME_RESET;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            pre_cnt_q  <= '0;
            mtip_q     <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            pre_cnt_q  <= pre_cnt_d;
            mtip_q     <= (mtime_q >= mtimecmp_q);
            dat_q      <= rd_en ? rdata : '0;
        end
    end

    // Responses are qualified with rst_ni so a response already registered
    // when reset arrives is never presented to the master.
    assign wbs.wbs_ack_o = rst_ni & (state_q == BUS_ACK);
    assign wbs.wbs_err_o = rst_ni & (state_q == BUS_ERR);
    assign wbs.wbs_dat_o = rst_ni ? dat_q : '0;

    assign xint_mtip_o = mtip_q;
    assign xint_msip_o = msip_q;

endmodule
